// File: rtl/edge_sample_pkg.sv
// Shared types for the debounced edge sampler.
// Debounce states and event polarity codes.
package edge_sample_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } state_t;

  localparam logic EVT_FALL = 1'b0;
  localparam logic EVT_RISE = 1'b1;

endpackage

// File: rtl/edge_sample_ctrl_tick.sv
// Sample-strobe generator: one-cycle tick every DIV_MAX+1 clocks.
// Used as a clock enable by the debounce FSM.
module tick_gen #(
  parameter int DIV_MAX = 49999
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/edge_sample_ctrl.sv
// Debounced edge detector with single-entry event buffer.
// Optional saturating rise counter built when EDGE_COUNT_EN is defined.
module edge_sample_ctrl
  import edge_sample_pkg::*;
#(
  parameter int DIV_MAX = 49999,
  parameter int DEB_CNT = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_rise,
  output logic             evt_ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] edge_count
);

  localparam int SW = $clog2(DEB_CNT + 1);

  logic          sync_q;
  logic          sig_s;
  logic          tick;
  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] stab;
  logic [SW-1:0] stab_nx;
  logic [SW-1:0] stab_inc;
  logic          hit;
  logic          rise_nx;
  logic          fall_nx;
  logic          push;
  logic          pop;

  tick_gen #(
    .DIV_MAX(DIV_MAX)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      sig_s  <= 1'b0;
    end else begin
      sync_q <= signal_in;
      sig_s  <= sync_q;
    end
  end

  assign stab_inc = stab + SW'(1);
  assign hit      = (stab_inc == SW'(DEB_CNT));

  // stab is 0 in the stable states, so DEB_CNT=1 confirms straight away
  always_comb begin
    state_nx = state;
    stab_nx  = stab;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    if (tick) begin
      unique case (state)
        S_LOW, S_RISE_CHK: begin
          if (!sig_s) begin
            state_nx = S_LOW;
            stab_nx  = '0;
          end else if (hit) begin
            state_nx = S_HIGH;
            stab_nx  = '0;
            rise_nx  = 1'b1;
          end else begin
            state_nx = S_RISE_CHK;
            stab_nx  = stab_inc;
          end
        end
        S_HIGH, S_FALL_CHK: begin
          if (sig_s) begin
            state_nx = S_HIGH;
            stab_nx  = '0;
          end else if (hit) begin
            state_nx = S_LOW;
            stab_nx  = '0;
            fall_nx  = 1'b1;
          end else begin
            state_nx = S_FALL_CHK;
            stab_nx  = stab_inc;
          end
        end
        default: begin
          state_nx = S_LOW;
          stab_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_LOW;
      stab       <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      stab       <= stab_nx;
      rise_pulse <= rise_nx;
      fall_pulse <= fall_nx;
    end
  end

  assign level = (state == S_HIGH) || (state == S_FALL_CHK);

  assign push = rise_pulse | fall_pulse;
  assign pop  = evt_valid & evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_rise  <= 1'b0;
      evt_ovf   <= 1'b0;
    end else begin
      if (ovf_clr)
        evt_ovf <= 1'b0;
      if (push && (!evt_valid || pop)) begin
        evt_valid <= 1'b1;
        evt_rise  <= rise_pulse ? EVT_RISE : EVT_FALL;
      end else if (push) begin
        evt_ovf <= 1'b1;
      end else if (pop) begin
        evt_valid <= 1'b0;
      end
    end
  end

`ifdef EDGE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      edge_count <= '0;
    else if (rise_pulse && (edge_count != '1))
      edge_count <= edge_count + CNT_W'(1);
  end
`else
  assign edge_count = '0;
`endif

endmodule
